// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: types shared by the arbiter and its picker
package uart_tx_arbiter_pkg;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational round-robin picker, searching upward from ptr+1 with wrap
module uart_tx_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  // Walking the search order backwards leaves the first hit as the final assignment.
  always_comb begin
    onehot = '0;
    idx = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (req[j]) begin
        onehot = '0;
        onehot[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among N byte-stream requesters, one whole message at a time
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int HOLD_MAX = 2048
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  input  logic [8*N-1:0] data,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_ready
);
  localparam int W = $clog2(N);
  localparam int HW = $clog2(HOLD_MAX);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_LO, WAIT_HI} state_t;
  state_t state, state_n;
  logic [W-1:0] ptr, ptr_n, own, own_n, pick_idx;
  logic [N-1:0] grant_n, ack_n, pick_oh;
  logic tx_start_n, end_flag, end_n;
  logic [HW-1:0] hold_cnt, hold_n;
  byte_t tx_data_n;
  byte_t bytes [N];
  for (genvar i = 0; i < N; i++) begin : g_byte
    assign bytes[i] = data[8*i +: 8];
  end
  uart_tx_arbiter_rr_pick #(.N(N), .W(W)) u_pick (
    .req(req),
    .ptr(ptr),
    .onehot(pick_oh),
    .idx(pick_idx)
  );
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    own_n = own;
    grant_n = grant;
    ack_n = '0;
    tx_start_n = 1'b0;
    tx_data_n = tx_data;
    hold_n = hold_cnt;
    end_n = end_flag;
    case (state)
      IDLE: if (|req) begin
        grant_n = pick_oh;
        own_n = pick_idx;
        hold_n = '0;
        state_n = LOAD;
      end
      LOAD: if (req[own]) begin
        if (tx_ready) begin
          tx_start_n = 1'b1;
          ack_n = grant;
          tx_data_n = bytes[own];
          end_n = last[own];
          hold_n = '0;
          state_n = WAIT_LO;
        end
      end else if (hold_cnt == HW'(HOLD_MAX - 1)) begin
        grant_n = '0;
        ptr_n = own;
        state_n = IDLE;
      end else begin
        hold_n = hold_cnt + 1'b1;
      end
      WAIT_LO: state_n = tx_ready ? WAIT_LO : WAIT_HI;
      WAIT_HI: if (tx_ready) begin
        grant_n = end_flag ? '0 : grant;
        ptr_n = end_flag ? own : ptr;
        state_n = end_flag ? IDLE : LOAD;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      ptr <= W'(N - 1);
      own <= '0;
      grant <= '0;
      ack <= '0;
      tx_start <= 1'b0;
      tx_data <= 8'h00;
      hold_cnt <= '0;
      end_flag <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      own <= own_n;
      grant <= grant_n;
      ack <= ack_n;
      tx_start <= tx_start_n;
      tx_data <= tx_data_n;
      hold_cnt <= hold_n;
      end_flag <= end_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a behavioural uart_tx busy model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int HOLD_MAX = 8;
  localparam int FRAME = 12;
  typedef struct packed {logic [7:0] b; logic l;} item_t;
  typedef struct packed {logic [1:0] idx; logic [7:0] b;} exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0] req, last, ack, grant;
  logic [8*N-1:0] data;
  logic tx_start, tx_ready;
  logic [7:0] tx_data;
  int busy;
  item_t mq [N][$];
  exp_t exp_q [$];
  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk),
    .rstn(rstn),
    .req(req),
    .last(last),
    .data(data),
    .ack(ack),
    .grant(grant),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy for FRAME cycles after each start, idle again on reset
  assign tx_ready = (busy == 0);
  always @(posedge clk or negedge rstn) begin
    if (!rstn) busy <= 0;
    else if (tx_start) busy <= FRAME;
    else if (busy != 0) busy <= busy - 1;
  end

  // requesters: present the head of each message queue, advance on ack
  initial begin
    req = '0;
    last = '0;
    data = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (ack[i] && mq[i].size() != 0) void'(mq[i].pop_front());
        req[i] = (mq[i].size() != 0);
        data[8*i +: 8] = 8'h00;
        last[i] = 1'b0;
        if (req[i]) begin
          data[8*i +: 8] = mq[i][0].b;
          last[i] = mq[i][0].l;
        end
      end
    end
  end

  // scoreboard: every start/ack must match the next expected byte and owner
  initial begin
    exp_t e;
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start || ack != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: tx_start=%b tx_data=%h ack=%b, expected no transfer", tx_start, tx_data, ack);
        end else begin
          e = exp_q.pop_front();
          if (tx_start !== 1'b1 || tx_data !== e.b || ack !== (4'b0001 << e.idx) || grant !== (4'b0001 << e.idx)) begin
            errors++;
            $display("FAIL sb_byte: got start=%b data=%h ack=%b grant=%b, want start=1 data=%h owner=%0d",
                     tx_start, tx_data, ack, grant, e.b, e.idx);
          end
        end
        checks++;
        if (tx_start && (!tx_ready || prev_start)) begin
          errors++;
          $display("FAIL start_rule: tx_ready=%b prev_start=%b, want tx_ready=1 prev_start=0", tx_ready, prev_start);
        end
      end
      prev_start = tx_start;
    end
  end

  task automatic push_byte(input int r, input logic [7:0] b, input logic l, input bit ex);
    item_t it;
    exp_t e;
    it.b = b;
    it.l = l;
    mq[r].push_back(it);
    if (ex) begin
      e.idx = 2'(r);
      e.b = b;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_msg(input int r, input string s, input bit ex);
    for (int k = 0; k < s.len(); k++) push_byte(r, s[k], k == s.len() - 1, ex);
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    for (int i = 0; i < N; i++) mq[i].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    @(negedge clk);
    while (tx_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_start_timeout: tx_start=%b, want 1", name, tx_start);
    end
  endtask

  task automatic wait_ready(input logic v, input string name);
    int n = 0;
    while (tx_ready !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_ready_timeout: tx_ready=%b, want %b", name, tx_ready, v);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    int pend;
    pend = 1;
    while ((exp_q.size() != 0 || grant != '0 || !tx_ready || pend != 0) && n < 3000) begin
      @(negedge clk);
      n++;
      pend = 0;
      for (int i = 0; i < N; i++) pend += mq[i].size();
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes outstanding grant=%b, want 0 and 0000", name, exp_q.size(), grant);
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if (ack !== '0 || grant !== '0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: ack=%b grant=%b start=%b data=%h, want all zero", ack, grant, tx_start, tx_data);
    end
  endtask

  task automatic test_single;
    @(negedge clk);
    push_byte(0, 8'h48, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_t0: grant=%b, want 0000", grant);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL single_t1: grant=%b start=%b, want 0001 0", grant, tx_start);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || ack !== 4'b0001 || tx_data !== 8'h48) begin
      errors++;
      $display("FAIL single_t2: start=%b ack=%b data=%h, want 1 0001 48", tx_start, ack, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || ack !== 4'b0000 || tx_data !== 8'h48) begin
      errors++;
      $display("FAIL single_pulse: start=%b ack=%b data=%h, want 0 0000 48", tx_start, ack, tx_data);
    end
    wait_ready(1'b1, "single");
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL single_hold: grant=%b, want 0001", grant);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_release: grant=%b, want 0000", grant);
    end
    wait_done("single");
  endtask

  task automatic test_interleave;
    int n = 0;
    do_reset;
    push_msg(0, "ABC", 1'b1);
    push_msg(2, "xyz", 1'b1);
    while (!(tx_start === 1'b1 && tx_data === 8'h43) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL interleave_owner_at_C: grant=%b waited=%0d, want 0001", grant, n);
    end
    wait_done("interleave");
  endtask

  task automatic test_fairness;
    do_reset;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push_byte(i, 8'(8'h10 * (i + 1) + k), 1'b1, 1'b1);
    wait_done("fairness");
  endtask

  task automatic test_hold_timeout;
    do_reset;
    push_byte(1, 8'h55, 1'b0, 1'b1);
    push_byte(3, 8'h33, 1'b1, 1'b1);
    wait_start("hold");
    @(negedge clk);
    wait_ready(1'b1, "hold");
    repeat (HOLD_MAX) @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL hold_kept: grant=%b, want 0010", grant);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL hold_release: grant=%b, want 0000", grant);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL hold_next: grant=%b, want 1000", grant);
    end
    wait_done("hold");
    do_reset;
    push_byte(1, 8'h55, 1'b0, 1'b1);
    push_byte(3, 8'h33, 1'b1, 1'b0);
    wait_start("rehold");
    @(negedge clk);
    wait_ready(1'b1, "rehold");
    repeat (HOLD_MAX - 2) @(negedge clk);
    push_byte(1, 8'h66, 1'b1, 1'b1);
    exp_q.push_back('{idx: 2'd3, b: 8'h33});
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || grant !== 4'b0010 || tx_data !== 8'h66) begin
      errors++;
      $display("FAIL rehold_send: start=%b grant=%b data=%h, want 1 0010 66", tx_start, grant, tx_data);
    end
    wait_done("rehold");
  endtask

  task automatic test_reset_mid;
    do_reset;
    push_msg(1, "12", 1'b1);
    wait_start("midrst");
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (ack !== '0 || grant !== '0 || tx_start !== 1'b0 || tx_data !== 8'h00 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_clear: ack=%b grant=%b start=%b data=%h ready=%b, want 0 0 0 00 1",
               ack, grant, tx_start, tx_data, tx_ready);
    end
    for (int i = 0; i < N; i++) mq[i].delete();
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    push_byte(0, 8'hD0, 1'b1, 1'b1);
    push_byte(3, 8'hD3, 1'b1, 1'b1);
    wait_done("midrst");
  endtask

  task automatic test_back_to_back;
    int n;
    push_msg(2, "WXYZ", 1'b1);
    wait_start("gap");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wait_ready(1'b0, "gap");
      wait_ready(1'b1, "gap");
      n = 0;
      while (tx_start !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n > 2) begin
        errors++;
        $display("FAIL gap_%0d: %0d cycles from tx_ready rise to tx_start, want <= 2", k, n);
      end
    end
    wait_done("gap");
  endtask

  initial begin
    test_reset;
    test_single;
    test_interleave;
    test_fairness;
    test_hold_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
